frame_buffer_rwm: RTL



---
 rtl/frame_buffer_rwm.sv | 123 ++++++++++++
 1 files changed

// File: rtl/frame_buffer_rwm.sv
// rtl/frame_buffer_rwm.sv - parametrised pixel frame store with handshaked write/read and word-per-cycle clear
module frame_buffer_rwm #(
    parameter int DATA_W   = 8,
    parameter int N_COLS   = 450,
    parameter int N_ROWS   = 450,
    parameter int CHANNELS = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [1:0]                               mode,
    input  logic [DATA_W-1:0]                        wr_data,
    input  logic                                     wr_valid,
    output logic                                     wr_ready,
    output logic [DATA_W-1:0]                        rd_data,
    output logic                                     rd_valid,
    input  logic                                     rd_ready,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] rd_chan,
    output logic                                     rd_last,
    output logic                                     busy,
    output logic                                     done
);

    localparam int DEPTH  = N_COLS * N_ROWS * CHANNELS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [CHAN_W-1:0] chan_cnt;
    logic              wr_fire;
    logic              rd_fetch;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    assign wr_ready  = (state == S_WRITE);
    assign busy      = (state != S_IDLE);
    assign wr_fire   = wr_ready && wr_valid;
    // Once the last word is registered nothing more is fetched, so ptr never needs to reach DEPTH.
    assign rd_fetch  = (state == S_READ) && !(rd_valid && rd_last) && (!rd_valid || rd_ready);
    assign mem_we    = wr_fire || (state == S_CLEAR);
    assign mem_wdata = (state == S_CLEAR) ? '0 : wr_data;

    // Storage has no reset so frame contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            chan_cnt <= '0;
            done     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_chan  <= '0;
            rd_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr      <= '0;
                        chan_cnt <= '0;
                        case (mode)
                            2'b00:   state <= S_READ;
                            2'b01:   state <= S_WRITE;
                            2'b10:   state <= S_CLEAR;
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == LAST_ADDR) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (rd_fetch) begin
                        rd_data  <= mem[ptr];
                        rd_valid <= 1'b1;
                        rd_chan  <= chan_cnt;
                        rd_last  <= (ptr == LAST_ADDR);
                        chan_cnt <= (chan_cnt == LAST_CHAN) ? '0 : chan_cnt + 1'b1;
                        ptr      <= ptr + 1'b1;
                    end else if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        if (rd_last) begin
                            rd_last <= 1'b0;
                            state   <= S_IDLE;
                            done    <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
